// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions used by the capture, arbiter and display-driver blocks.
package fb_pkg;

  localparam int IMAGE_SIZE = 3840;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ARMED = 1'b1
  } swap_state_e;

endpackage

// File: rtl/fb_swap_fsm.sv
// Double-buffer swap controller: counts captured pixels and decides at each capture
// frame boundary whether the freshly written bank can be handed to the driver.
module fb_swap_fsm
  import fb_pkg::*;
#(
  parameter int IMAGE_SIZE = fb_pkg::IMAGE_SIZE,
  parameter int CNT_WIDTH  = $clog2(IMAGE_SIZE + 1)
) (
  input  logic       rgbClk,
  input  logic       nrst,
  input  logic       frame_start,
  input  logic       wr_accept,
  input  logic       rd_busy,
  output logic       swap_now,
  output logic       read_bank,
  output logic       frame_valid,
  output logic       swap_pulse,
  output logic [7:0] dropped_frames
);

  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(IMAGE_SIZE);
  localparam logic [CNT_WIDTH-1:0] ONE_COUNT  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  swap_state_e          state_r;
  swap_state_e          state_next_s;
  logic [CNT_WIDTH-1:0] pix_count_r;
  logic                 count_full_s;
  logic                 swap_now_s;
  logic                 drop_now_s;
  logic                 read_bank_r;
  logic                 frame_valid_r;
  logic                 swap_pulse_r;
  logic [7:0]           dropped_r;

  assign count_full_s = (pix_count_r == FULL_COUNT);

  // swap state register
  always_ff @(posedge rgbClk or negedge nrst) begin
    if (!nrst) begin
      state_r <= FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next state and swap/drop decisions for the current frame boundary
  always_comb begin
    state_next_s = state_r;
    swap_now_s   = 1'b0;
    drop_now_s   = 1'b0;
    case (state_r)
      FILL: begin
        if (frame_start) begin
          drop_now_s = 1'b1;
        end else if (count_full_s) begin
          state_next_s = ARMED;
        end else begin
          state_next_s = FILL;
        end
      end
      ARMED: begin
        if (frame_start) begin
          state_next_s = FILL;
          if (rd_busy) begin
            drop_now_s = 1'b1;
          end else begin
            swap_now_s = 1'b1;
          end
        end else begin
          state_next_s = ARMED;
        end
      end
      default: begin
        state_next_s = FILL;
      end
    endcase
  end

  // pixel counter; a write on the boundary cycle is pixel 1 of the new frame
  always_ff @(posedge rgbClk or negedge nrst) begin
    if (!nrst) begin
      pix_count_r <= '0;
    end else if (frame_start) begin
      pix_count_r <= wr_accept ? ONE_COUNT : '0;
    end else if (wr_accept && !count_full_s) begin
      pix_count_r <= pix_count_r + ONE_COUNT;
    end else begin
      pix_count_r <= pix_count_r;
    end
  end

  // bank ownership, frame-valid flag, swap pulse and dropped-frame counter
  always_ff @(posedge rgbClk or negedge nrst) begin
    if (!nrst) begin
      read_bank_r   <= 1'b1;
      frame_valid_r <= 1'b0;
      swap_pulse_r  <= 1'b0;
      dropped_r     <= 8'd0;
    end else begin
      swap_pulse_r <= swap_now_s;
      if (swap_now_s) begin
        read_bank_r   <= ~read_bank_r;
        frame_valid_r <= 1'b1;
      end else begin
        read_bank_r   <= read_bank_r;
        frame_valid_r <= frame_valid_r;
      end
      if (drop_now_s && (dropped_r != 8'hFF)) begin
        dropped_r <= dropped_r + 8'd1;
      end else begin
        dropped_r <= dropped_r;
      end
    end
  end

  assign swap_now       = swap_now_s;
  assign read_bank      = read_bank_r;
  assign frame_valid    = frame_valid_r;
  assign swap_pulse     = swap_pulse_r;
  assign dropped_frames = dropped_r;

endmodule

// File: rtl/fb_bank_arbiter.sv
// Single-port frame-buffer RAM arbiter: capture writes win over driver reads, and the
// bank MSB of the RAM address follows the double-buffer swap controller.
module fb_bank_arbiter
  import fb_pkg::*;
#(
  parameter int PIX_ADDR_WIDTH = 12,
  parameter int RAM_DATA_WIDTH = 16,
  parameter int IMAGE_SIZE     = fb_pkg::IMAGE_SIZE
) (
  input  logic                      rgbClk,
  input  logic                      nrst,
  input  logic                      wrEn,
  input  logic [PIX_ADDR_WIDTH-1:0] wrAddr,
  input  logic [RAM_DATA_WIDTH-1:0] wrData,
  input  logic                      frameStart,
  input  logic                      rdReq,
  input  logic [PIX_ADDR_WIDTH-1:0] rdAddr,
  input  logic                      rdBusy,
  output logic                      rdGrant,
  output logic                      rdValid,
  output logic [RAM_DATA_WIDTH-1:0] rdData,
  output logic [PIX_ADDR_WIDTH:0]   ramAddr,
  output logic [RAM_DATA_WIDTH-1:0] ramWData,
  output logic                      ramWe,
  input  logic [RAM_DATA_WIDTH-1:0] ramRData,
  output logic                      readBank,
  output logic                      frameValid,
  output logic                      swapPulse,
  output logic [7:0]                droppedFrames
);

  localparam logic [PIX_ADDR_WIDTH:0] ADDR_LIMIT = (PIX_ADDR_WIDTH + 1)'(IMAGE_SIZE);

  logic                      wr_accept_s;
  logic                      rd_grant_s;
  logic                      swap_now_s;
  logic                      read_bank_s;
  logic                      bank_sel_s;
  logic [PIX_ADDR_WIDTH:0]   ram_addr_r;
  logic [RAM_DATA_WIDTH-1:0] ram_wdata_r;
  logic                      ram_we_r;
  logic                      rd_pend_r;
  logic                      rd_valid_r;

  assign wr_accept_s = wrEn && ({1'b0, wrAddr} < ADDR_LIMIT);
  assign rd_grant_s  = rdReq & ~wrEn;
  // On a swap cycle the access already targets the post-swap bank assignment.
  assign bank_sel_s  = read_bank_s ^ swap_now_s;

  fb_swap_fsm #(
    .IMAGE_SIZE(IMAGE_SIZE),
    .CNT_WIDTH ($clog2(IMAGE_SIZE + 1))
  ) u_swap_fsm (
    .rgbClk        (rgbClk),
    .nrst          (nrst),
    .frame_start   (frameStart),
    .wr_accept     (wr_accept_s),
    .rd_busy       (rdBusy),
    .swap_now      (swap_now_s),
    .read_bank     (read_bank_s),
    .frame_valid   (frameValid),
    .swap_pulse    (swapPulse),
    .dropped_frames(droppedFrames)
  );

  // RAM port registers and the two-stage read-valid pipeline
  always_ff @(posedge rgbClk or negedge nrst) begin
    if (!nrst) begin
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_we_r    <= 1'b0;
      rd_pend_r   <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else begin
      ram_we_r   <= wr_accept_s;
      rd_pend_r  <= rd_grant_s;
      rd_valid_r <= rd_pend_r;
      if (wr_accept_s) begin
        ram_addr_r  <= {~bank_sel_s, wrAddr};
        ram_wdata_r <= wrData;
      end else if (rd_grant_s) begin
        ram_addr_r  <= {bank_sel_s, rdAddr};
        ram_wdata_r <= ram_wdata_r;
      end else begin
        ram_addr_r  <= ram_addr_r;
        ram_wdata_r <= ram_wdata_r;
      end
    end
  end

  assign rdGrant  = rd_grant_s;
  assign rdValid  = rd_valid_r;
  assign rdData   = rd_valid_r ? ramRData : '0;
  assign ramAddr  = ram_addr_r;
  assign ramWData = ram_wdata_r;
  assign ramWe    = ram_we_r;
  assign readBank = read_bank_s;

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// Directed self-checking bench for fb_bank_arbiter with a one-cycle-latency RAM model.
module tb_fb_bank_arbiter;
  import fb_pkg::*;

  logic        rgbClk;
  logic        nrst;
  logic        wrEn;
  logic [11:0] wrAddr;
  logic [15:0] wrData;
  logic        frameStart;
  logic        rdReq;
  logic [11:0] rdAddr;
  logic        rdBusy;
  logic        rdGrant;
  logic        rdValid;
  logic [15:0] rdData;
  logic [12:0] ramAddr;
  logic [15:0] ramWData;
  logic        ramWe;
  logic [15:0] ramRData;
  logic        readBank;
  logic        frameValid;
  logic        swapPulse;
  logic [7:0]  droppedFrames;

  int checks = 0;
  int failures = 0;

  fb_bank_arbiter #(
    .PIX_ADDR_WIDTH(12),
    .RAM_DATA_WIDTH(16),
    .IMAGE_SIZE    (3840)
  ) dut (
    .rgbClk       (rgbClk),
    .nrst         (nrst),
    .wrEn         (wrEn),
    .wrAddr       (wrAddr),
    .wrData       (wrData),
    .frameStart   (frameStart),
    .rdReq        (rdReq),
    .rdAddr       (rdAddr),
    .rdBusy       (rdBusy),
    .rdGrant      (rdGrant),
    .rdValid      (rdValid),
    .rdData       (rdData),
    .ramAddr      (ramAddr),
    .ramWData     (ramWData),
    .ramWe        (ramWe),
    .ramRData     (ramRData),
    .readBank     (readBank),
    .frameValid   (frameValid),
    .swapPulse    (swapPulse),
    .droppedFrames(droppedFrames)
  );

  initial rgbClk = 1'b0;
  always #5 rgbClk = ~rgbClk;

  // RAM model: data returned is a tag plus the address registered at the previous edge
  always @(posedge rgbClk) ramRData <= {3'b101, ramAddr};

  task automatic tick();
    @(posedge rgbClk);
    @(negedge rgbClk);
  endtask

  task automatic idle_inputs();
    wrEn = 1'b0; wrAddr = 12'd0; wrData = 16'd0; frameStart = 1'b0;
    rdReq = 1'b0; rdAddr = 12'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdBusy = 1'b0;
    nrst = 1'b0;
    @(negedge rgbClk);
    @(negedge rgbClk);
    nrst = 1'b1;
  endtask

  task automatic write_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      wrEn = 1'b1;
      wrAddr = 12'(i);
      wrData = 16'(i) ^ 16'hA5A5;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rdBusy = 1'b0;
    nrst = 1'b0;
    @(negedge rgbClk);
    checks++; if (readBank !== 1'b1) begin failures++; $display("FAIL reset_readBank act=%0h exp=1", readBank); end
    checks++; if (frameValid !== 1'b0) begin failures++; $display("FAIL reset_frameValid act=%0h exp=0", frameValid); end
    checks++; if (ramAddr !== 13'h0000) begin failures++; $display("FAIL reset_ramAddr act=%0h exp=0", ramAddr); end
    checks++; if (ramWe !== 1'b0) begin failures++; $display("FAIL reset_ramWe act=%0h exp=0", ramWe); end
    checks++; if (droppedFrames !== 8'd0) begin failures++; $display("FAIL reset_dropped act=%0d exp=0", droppedFrames); end
    nrst = 1'b1;
    tick();
    checks++; if (rdValid !== 1'b0 || swapPulse !== 1'b0) begin failures++; $display("FAIL reset_idle_outputs act=%0h%0h exp=00", rdValid, swapPulse); end
  endtask

  task automatic test_full_swap();
    int pulses;
    write_pixels(3840);
    checks++; if (ramAddr !== 13'h0EFF) begin failures++; $display("FAIL fill_last_addr act=%0h exp=eff", ramAddr); end
    checks++; if (ramWData !== 16'hAB5A) begin failures++; $display("FAIL fill_last_data act=%0h exp=ab5a", ramWData); end
    checks++; if (dut.u_swap_fsm.pix_count_r !== 12'd3840) begin failures++; $display("FAIL fill_count act=%0d exp=3840", dut.u_swap_fsm.pix_count_r); end
    tick();
    tick();
    checks++; if (dut.u_swap_fsm.state_r !== ARMED) begin failures++; $display("FAIL fill_armed act=%0d exp=1", dut.u_swap_fsm.state_r); end
    frameStart = 1'b1; rdBusy = 1'b0;
    wrEn = 1'b1; wrAddr = 12'd9; wrData = 16'h0909;
    tick();
    idle_inputs();
    checks++; if (readBank !== 1'b0) begin failures++; $display("FAIL swap_readBank act=%0h exp=0", readBank); end
    checks++; if (frameValid !== 1'b1) begin failures++; $display("FAIL swap_frameValid act=%0h exp=1", frameValid); end
    checks++; if (ramAddr !== 13'h1009 || ramWe !== 1'b1) begin failures++; $display("FAIL swap_coincident_write act=%0h/%0h exp=1009/1", ramAddr, ramWe); end
    checks++; if (dut.u_swap_fsm.pix_count_r !== 12'd1) begin failures++; $display("FAIL swap_count act=%0d exp=1", dut.u_swap_fsm.pix_count_r); end
    checks++; if (droppedFrames !== 8'd0) begin failures++; $display("FAIL swap_dropped act=%0d exp=0", droppedFrames); end
    pulses = swapPulse ? 1 : 0;
    repeat (4) begin
      tick();
      if (swapPulse) pulses++;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL swap_pulse_count act=%0d exp=1", pulses); end
  endtask

  task automatic test_busy_drop();
    do_reset();
    write_pixels(3840);
    tick();
    tick();
    frameStart = 1'b1; rdBusy = 1'b1;
    tick();
    idle_inputs();
    rdBusy = 1'b0;
    checks++; if (readBank !== 1'b1) begin failures++; $display("FAIL busy_readBank act=%0h exp=1", readBank); end
    checks++; if (swapPulse !== 1'b0) begin failures++; $display("FAIL busy_swapPulse act=%0h exp=0", swapPulse); end
    checks++; if (droppedFrames !== 8'd1) begin failures++; $display("FAIL busy_dropped act=%0d exp=1", droppedFrames); end
    checks++; if (frameValid !== 1'b0) begin failures++; $display("FAIL busy_frameValid act=%0h exp=0", frameValid); end
    checks++; if (dut.u_swap_fsm.state_r !== FILL) begin failures++; $display("FAIL busy_state act=%0d exp=0", dut.u_swap_fsm.state_r); end
    tick();
    checks++; if (swapPulse !== 1'b0) begin failures++; $display("FAIL busy_late_pulse act=%0h exp=0", swapPulse); end
  endtask

  task automatic test_partial_drop();
    do_reset();
    write_pixels(100);
    checks++; if (dut.u_swap_fsm.pix_count_r !== 12'd100) begin failures++; $display("FAIL partial_count act=%0d exp=100", dut.u_swap_fsm.pix_count_r); end
    frameStart = 1'b1;
    tick();
    idle_inputs();
    checks++; if (droppedFrames !== 8'd1) begin failures++; $display("FAIL partial_dropped act=%0d exp=1", droppedFrames); end
    checks++; if (dut.u_swap_fsm.pix_count_r !== 12'd0) begin failures++; $display("FAIL partial_cleared act=%0d exp=0", dut.u_swap_fsm.pix_count_r); end
    checks++; if (readBank !== 1'b1 || swapPulse !== 1'b0) begin failures++; $display("FAIL partial_noswap act=%0h%0h exp=10", readBank, swapPulse); end
  endtask

  task automatic test_arbitration();
    do_reset();
    wrEn = 1'b1; wrAddr = 12'd20; wrData = 16'h1234;
    rdReq = 1'b1; rdAddr = 12'd5;
    #1;
    checks++; if (rdGrant !== 1'b0) begin failures++; $display("FAIL arb_write_priority act=%0h exp=0", rdGrant); end
    tick();
    checks++; if (ramWe !== 1'b1 || ramAddr !== 13'h0014 || ramWData !== 16'h1234) begin failures++; $display("FAIL arb_write act=%0h/%0h/%0h exp=1/14/1234", ramWe, ramAddr, ramWData); end
    wrEn = 1'b0;
    #1;
    checks++; if (rdGrant !== 1'b1) begin failures++; $display("FAIL arb_read_grant act=%0h exp=1", rdGrant); end
    tick();
    rdReq = 1'b0;
    checks++; if (ramWe !== 1'b0 || ramAddr !== 13'h1005 || rdValid !== 1'b0) begin failures++; $display("FAIL arb_read_addr act=%0h/%0h/%0h exp=0/1005/0", ramWe, ramAddr, rdValid); end
    tick();
    checks++; if (rdValid !== 1'b1 || rdData !== 16'hB005) begin failures++; $display("FAIL arb_read_data act=%0h/%0h exp=1/b005", rdValid, rdData); end
    tick();
    checks++; if (rdValid !== 1'b0 || ramAddr !== 13'h1005) begin failures++; $display("FAIL arb_idle_hold act=%0h/%0h exp=0/1005", rdValid, ramAddr); end
  endtask

  task automatic test_out_of_range();
    wrEn = 1'b1; wrAddr = 12'd3840; wrData = 16'hFFFF;
    rdReq = 1'b1; rdAddr = 12'd1;
    #1;
    checks++; if (rdGrant !== 1'b0) begin failures++; $display("FAIL oor_grant act=%0h exp=0", rdGrant); end
    tick();
    checks++; if (ramWe !== 1'b0 || ramAddr !== 13'h1005) begin failures++; $display("FAIL oor_discard act=%0h/%0h exp=0/1005", ramWe, ramAddr); end
    checks++; if (dut.u_swap_fsm.pix_count_r !== 12'd1) begin failures++; $display("FAIL oor_count act=%0d exp=1", dut.u_swap_fsm.pix_count_r); end
    rdReq = 1'b0; wrAddr = 12'd3839; wrData = 16'h0F0F;
    tick();
    idle_inputs();
    checks++; if (ramWe !== 1'b1 || ramAddr !== 13'h0EFF || dut.u_swap_fsm.pix_count_r !== 12'd2) begin failures++; $display("FAIL oor_last_valid act=%0h/%0h/%0d exp=1/eff/2", ramWe, ramAddr, dut.u_swap_fsm.pix_count_r); end
  endtask

  task automatic test_reset_midframe();
    int seen;
    do_reset();
    write_pixels(5);
    rdReq = 1'b1; rdAddr = 12'd7;
    tick();
    idle_inputs();
    #2;
    nrst = 1'b0;
    #1;
    checks++; if (readBank !== 1'b1 || frameValid !== 1'b0 || swapPulse !== 1'b0) begin failures++; $display("FAIL mid_reset_flags act=%0h%0h%0h exp=100", readBank, frameValid, swapPulse); end
    checks++; if (rdValid !== 1'b0 || ramWe !== 1'b0 || ramAddr !== 13'h0000 || ramWData !== 16'h0000) begin failures++; $display("FAIL mid_reset_port act=%0h/%0h/%0h/%0h exp=0/0/0/0", rdValid, ramWe, ramAddr, ramWData); end
    checks++; if (droppedFrames !== 8'd0 || dut.u_swap_fsm.pix_count_r !== 12'd0 || dut.u_swap_fsm.state_r !== FILL) begin failures++; $display("FAIL mid_reset_fsm act=%0d/%0d/%0d exp=0/0/0", droppedFrames, dut.u_swap_fsm.pix_count_r, dut.u_swap_fsm.state_r); end
    @(negedge rgbClk);
    nrst = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      if (rdValid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_reset_stale_valid act=%0d exp=0", seen); end
  endtask

  task automatic test_saturation();
    do_reset();
    frameStart = 1'b1;
    repeat (254) tick();
    checks++; if (droppedFrames !== 8'd254) begin failures++; $display("FAIL sat_pre act=%0d exp=254", droppedFrames); end
    repeat (6) tick();
    frameStart = 1'b0;
    checks++; if (droppedFrames !== 8'd255) begin failures++; $display("FAIL sat_hold act=%0d exp=255", droppedFrames); end
  endtask

  initial begin
    nrst = 1'b0;
    rdBusy = 1'b0;
    idle_inputs();
    @(negedge rgbClk);
    test_reset();
    test_full_swap();
    test_busy_drop();
    test_partial_drop();
    test_arbitration();
    test_out_of_range();
    test_reset_midframe();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
